// File: rtl/video_timing_gen_pkg.sv
// Shared types and constants for the raster timing generator: standard
// timing sets, FSM state encoding, pipe flag payload and bar colour table.
package video_timing_gen_pkg;

  localparam int unsigned POS_W = 11;
  localparam int unsigned RGB_W = 24;

  typedef enum logic [1:0] {
    MODE_720P  = 2'd0,
    MODE_1080P = 2'd1,
    MODE_480P  = 2'd2
  } vtg_mode_e;

  typedef struct packed {
    logic [15:0] h_sync;
    logic [15:0] h_back;
    logic [15:0] h_disp;
    logic [15:0] h_front;
    logic [15:0] v_sync;
    logic [15:0] v_back;
    logic [15:0] v_disp;
    logic [15:0] v_front;
  } vtg_timing_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vtg_state_e;

  // Sync/enable/frame flags travelling down the output pipe together
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic frame;
  } vtg_ctrl_t;

  // Standard CEA timing sets
  function automatic vtg_timing_t timing_set(input vtg_mode_e mode);
    vtg_timing_t t;
    case (mode)
      MODE_1080P: t = '{16'd44, 16'd148, 16'd1920, 16'd88, 16'd5, 16'd36, 16'd1080, 16'd4};
      MODE_480P:  t = '{16'd96, 16'd48, 16'd640, 16'd16, 16'd2, 16'd33, 16'd480, 16'd10};
      default:    t = '{16'd40, 16'd220, 16'd1280, 16'd110, 16'd5, 16'd20, 16'd720, 16'd5};
    endcase
    return t;
  endfunction

  localparam vtg_timing_t T720 = timing_set(MODE_720P);

  // Colour of one of the eight vertical test bars, left to right
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    logic [RGB_W-1:0] rgb;
    case (idx)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFFFF00;
      3'd2:    rgb = 24'h00FFFF;
      3'd3:    rgb = 24'h00FF00;
      3'd4:    rgb = 24'hFF00FF;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel request / video output bundle between the timing generator, the
// frame source and the TMDS transmitter.
interface video_timing_gen_if;
  import video_timing_gen_pkg::*;

  logic             data_req;
  logic [POS_W-1:0] pixel_xpos;
  logic [POS_W-1:0] pixel_ypos;
  logic [RGB_W-1:0] pixel_data;
  logic             video_hsync;
  logic             video_vsync;
  logic             video_de;
  logic [RGB_W-1:0] video_din;
  logic             frame_start;

  modport master (
    output data_req, pixel_xpos, pixel_ypos,
    output video_hsync, video_vsync, video_de, video_din, frame_start,
    input  pixel_data
  );

  modport slave (
    input  data_req, pixel_xpos, pixel_ypos,
    input  video_hsync, video_vsync, video_de, video_din, frame_start,
    output pixel_data
  );
endinterface

// File: rtl/video_timing_gen_bar_gen.sv
// video_bar_gen: maps an active x position to one of eight vertical colour
// bars. Only instantiated when TEST_PATTERN_EN is defined.
module video_bar_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned H_DISP = 1280
) (
  input  logic [POS_W-1:0] xpos,
  output logic [RGB_W-1:0] rgb_c
);

  localparam int unsigned BAR_W = (H_DISP >= 8) ? (H_DISP / 8) : 1;

  logic [POS_W-1:0] idx_c;

  // Bar index, clamped so odd widths never select past the last bar
  assign idx_c = xpos / POS_W'(BAR_W);
  assign rgb_c = bar_colour((idx_c > POS_W'(7)) ? 3'd7 : idx_c[2:0]);

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for the DVI/HDMI transmitter.
// Counters -> stage 1 (data_req, x/y) -> stage 2 (source returns pixel)
// -> stage 3 (hsync/vsync/de/din/frame_start), all outputs registered.
// Optional build macro: TEST_PATTERN_EN (colour bars selected by test_sel).
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned H_SYNC   = 32'(T720.h_sync),
  parameter int unsigned H_BACK   = 32'(T720.h_back),
  parameter int unsigned H_DISP   = 32'(T720.h_disp),
  parameter int unsigned H_FRONT  = 32'(T720.h_front),
  parameter int unsigned V_SYNC   = 32'(T720.v_sync),
  parameter int unsigned V_BACK   = 32'(T720.v_back),
  parameter int unsigned V_DISP   = 32'(T720.v_disp),
  parameter int unsigned V_FRONT  = 32'(T720.v_front),
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic             pclk,
  input  logic             rstin,
  input  logic             video_en,
  input  logic             test_sel,
  video_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_END   = HW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_END   = VW'(V_SYNC + V_BACK + V_DISP);

  vtg_state_e       state;
  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  vtg_ctrl_t        ctrl1;
  vtg_ctrl_t        ctrl2;
  logic             run_c;
  logic             act_c;
  logic             h_act_c;
  logic             v_act_c;
  logic [RGB_W-1:0] pix_c;

  assign run_c   = (state == ST_RUN);
  assign h_act_c = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
  assign v_act_c = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
  assign act_c   = run_c && h_act_c && v_act_c;

  // Run/idle control and raster counters; a frame always runs to its last cycle
  always_ff @(posedge pclk) begin
    if (rstin) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (video_en) state <= ST_RUN;
        end
        ST_RUN: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              v_cnt <= '0;
              if (!video_en) state <= ST_IDLE;
            end else begin
              v_cnt <= v_cnt + VW'(1);
            end
          end else begin
            h_cnt <= h_cnt + HW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: decode counters into the pixel request and flags
  always_ff @(posedge pclk) begin
    if (rstin) begin
      ctrl1          <= '0;
      vid.pixel_xpos <= '0;
      vid.pixel_ypos <= '0;
    end else begin
      ctrl1.hsync    <= run_c && (h_cnt < H_SYNC_END);
      ctrl1.vsync    <= run_c && (v_cnt < V_SYNC_END);
      ctrl1.de       <= act_c;
      ctrl1.frame    <= run_c && (h_cnt == '0) && (v_cnt == '0);
      vid.pixel_xpos <= act_c ? POS_W'(h_cnt - H_ACT_START) : '0;
      vid.pixel_ypos <= act_c ? POS_W'(v_cnt - V_ACT_START) : '0;
    end
  end

  assign vid.data_req = ctrl1.de;

  // Stage 2: hold flags while the source answers the request
  always_ff @(posedge pclk) begin
    if (rstin) ctrl2 <= '0;
    else       ctrl2 <= ctrl1;
  end

`ifdef TEST_PATTERN_EN
  logic [POS_W-1:0] bar_x;
  logic [RGB_W-1:0] bar_rgb_c;

  // Stage 2 copy of x for the bar lookup
  always_ff @(posedge pclk) begin
    if (rstin) bar_x <= '0;
    else       bar_x <= vid.pixel_xpos;
  end

  video_bar_gen #(.H_DISP(H_DISP)) u_bar_gen (
    .xpos  (bar_x),
    .rgb_c (bar_rgb_c)
  );

  assign pix_c = test_sel ? bar_rgb_c : vid.pixel_data;
`else
  logic unused_test_sel;
  assign unused_test_sel = test_sel;
  assign pix_c = vid.pixel_data;
`endif

  // Stage 3: transmitter-facing outputs, blanking forced black
  always_ff @(posedge pclk) begin
    if (rstin) begin
      vid.video_de    <= 1'b0;
      vid.video_hsync <= ~SYNC_POL;
      vid.video_vsync <= ~SYNC_POL;
      vid.frame_start <= 1'b0;
      vid.video_din   <= '0;
    end else begin
      vid.video_de    <= ctrl2.de;
      vid.video_hsync <= ctrl2.hsync ? SYNC_POL : ~SYNC_POL;
      vid.video_vsync <= ctrl2.vsync ? SYNC_POL : ~SYNC_POL;
      vid.frame_start <= ctrl2.frame;
      vid.video_din   <= ctrl2.de ? pix_c : '0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a small 14x7 raster. A frame-position
// model predicts requests, pixels and syncs into queues; a monitor pops
// and compares whenever the DUT presents them.
module tb_video_timing_gen;

  localparam int unsigned HS = 2, HB = 2, HD = 8, HF = 2;
  localparam int unsigned VS = 1, VB = 1, VD = 4, VF = 1;
  localparam int unsigned HT = HS + HB + HD + HF;
  localparam int unsigned VT = VS + VB + VD + VF;
  localparam int unsigned FT = HT * VT;

  logic pclk = 1'b0;
  logic rstin = 1'b1;
  logic video_en = 1'b0;
  logic test_sel = 1'b0;

  video_timing_gen_if vid();

  video_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .SYNC_POL(1'b1)
  ) dut (
    .pclk     (pclk),
    .rstin    (rstin),
    .video_en (video_en),
    .test_sel (test_sel),
    .vid      (vid)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          due;
    logic [10:0] x;
    logic [10:0] y;
    logic [23:0] din;
  } px_t;

  typedef struct {
    int   due;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

  px_t  req_q[$];
  px_t  pix_q[$];
  ctl_t ctl_q[$];
  int   lat_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int phase = 0;
  bit m_run = 0;
  int m_pos = 0;
  logic [7:0] salt = 8'h00;

  int win = 0, de_n = 0, hs_n = 0, vs_n = 0, last_fs = -1;
  int frames_done = 0, req_total = 0, de_total = 0;
  logic prev_hs = 1'b0;
  logic [23:0] line0[8];
  logic [23:0] bars[8];
  int line0_n = 0, bars_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] src_pix(input logic [10:0] x, input logic [10:0] y, input logic [7:0] s);
    return {s, y[7:0], x[7:0]};
  endfunction

  function automatic logic [23:0] bar_rgb(input int x);
    case (x)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_din(input int x, input int y);
`ifdef TEST_PATTERN_EN
    if (test_sel) return bar_rgb(x / int'(HD / 8));
`endif
    return src_pix(11'(x), 11'(y), salt);
  endfunction

  // Reference model: position within the frame, run/idle by frame rules
  always @(posedge pclk) begin : model
    int h, v;
    bit act;
    px_t e;
    ctl_t c;
    cyc++;
    if (rstin) begin
      m_run = 0;
      m_pos = 0;
      req_q.delete();
      pix_q.delete();
      ctl_q.delete();
      lat_q.delete();
      win = 0;
      last_fs = -1;
    end else if (m_run) begin
      h = m_pos % HT;
      v = m_pos / HT;
      act = (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);
      if (act) begin
        e.x = 11'(h - int'(HS + HB));
        e.y = 11'(v - int'(VS + VB));
        e.din = exp_din(h - int'(HS + HB), v - int'(VS + VB));
        e.due = cyc;
        req_q.push_back(e);
        e.due = cyc + 2;
        pix_q.push_back(e);
      end
      c.due = cyc + 2;
      c.hs = (h < HS);
      c.vs = (v < VS);
      c.fs = (m_pos == 0);
      ctl_q.push_back(c);
      if (m_pos == FT - 1) begin
        m_pos = 0;
        if (!video_en) m_run = 0;
      end else begin
        m_pos++;
      end
    end else if (video_en) begin
      m_run = 1;
      m_pos = 0;
    end
  end

  // Frame source: answers each request one cycle later, junk otherwise
  logic [23:0] pend;
  bit pend_v = 0;
  always @(negedge pclk) begin
    pend_v = vid.data_req;
    pend = src_pix(vid.pixel_xpos, vid.pixel_ypos, salt);
  end
  always @(posedge pclk) begin
    #1;
    vid.pixel_data = pend_v ? pend : 24'($urandom);
  end

  // Monitor: pops expectations as the DUT presents requests and pixels
  always @(negedge pclk) begin : monitor
    bit due_now;
    px_t e;
    ctl_t c;
    due_now = (req_q.size() > 0) && (req_q[0].due == cyc);
    check("data_req", 32'(vid.data_req), 32'(due_now));
    e.x = '0;
    e.y = '0;
    e.din = '0;
    if (due_now) e = req_q.pop_front();
    check("pixel_xpos", 32'(vid.pixel_xpos), 32'(e.x));
    check("pixel_ypos", 32'(vid.pixel_ypos), 32'(e.y));
    if (vid.data_req) begin
      req_total++;
      lat_q.push_back(cyc);
    end

    due_now = (pix_q.size() > 0) && (pix_q[0].due == cyc);
    check("video_de", 32'(vid.video_de), 32'(due_now));
    e.din = '0;
    if (due_now) e = pix_q.pop_front();
    check("video_din", 32'(vid.video_din), 32'(e.din));
    if (vid.video_de) begin
      de_total++;
      if (lat_q.size() > 0) check("req_to_de_latency", cyc - lat_q.pop_front(), 2);
      else check("de_without_req", 32'(vid.video_de), 32'(0));
      if (phase == 2 && line0_n < 8) begin line0[line0_n] = vid.video_din; line0_n++; end
      if (phase == 7 && bars_n < 8) begin bars[bars_n] = vid.video_din; bars_n++; end
    end

    c.hs = 0; c.vs = 0; c.fs = 0;
    if ((ctl_q.size() > 0) && (ctl_q[0].due == cyc)) c = ctl_q.pop_front();
    check("video_hsync", 32'(vid.video_hsync), 32'(c.hs));
    check("video_vsync", 32'(vid.video_vsync), 32'(c.vs));
    check("frame_start", 32'(vid.frame_start), 32'(c.fs));

    if (vid.frame_start) begin
      check("fs_with_hsync", 32'(vid.video_hsync), 32'(1));
      check("fs_with_vsync", 32'(vid.video_vsync), 32'(1));
      check("fs_first_hsync", 32'(prev_hs), 32'(0));
      check("frame_overlap", win, 0);
      if (phase == 2 && last_fs >= 0) check("frame_period", cyc - last_fs, FT);
      last_fs = cyc;
      win = FT; de_n = 0; hs_n = 0; vs_n = 0;
    end
    if (win > 0) begin
      de_n += int'(vid.video_de);
      hs_n += int'(vid.video_hsync);
      vs_n += int'(vid.video_vsync);
      win--;
      if (win == 0) begin
        check("frame_de_count", de_n, HD * VD);
        check("frame_hsync_count", hs_n, HS * VT);
        check("frame_vsync_count", vs_n, VS * HT);
        frames_done++;
      end
    end
    prev_hs = vid.video_hsync;
  end

  task automatic wait_frames(input int n);
    int start = frames_done;
    bit hit = 0;
    for (int i = 0; i < (n + 1) * int'(FT) + 20 && !hit; i++) begin
      @(posedge pclk); #1;
      hit = (frames_done >= start + n);
    end
    check("wait_frames", 32'(hit), 32'(1));
  endtask

  task automatic wait_pos(input int target);
    bit hit = 0;
    for (int i = 0; i < 3 * int'(FT) && !hit; i++) begin
      @(posedge pclk); #1;
      hit = m_run && (m_pos == target);
    end
    check("wait_pos", 32'(hit), 32'(1));
  endtask

  task automatic wait_idle();
    bit hit = 0;
    for (int i = 0; i < 3 * int'(FT) && !hit; i++) begin
      @(posedge pclk); #1;
      hit = !m_run;
    end
    check("wait_idle", 32'(hit), 32'(1));
  endtask

  // Stimulus
  initial begin : stim
    int snap;
    vid.pixel_data = '0;
    phase = 1;
    repeat (3) @(posedge pclk);
    #1 rstin = 1'b0;
    repeat (30) @(posedge pclk);
    #1 check("idle_no_data_req", req_total, 0);

    phase = 2;
    video_en = 1'b1;
    wait_frames(3);
    for (int i = 0; i < 8; i++) check("first_line_din", 32'(line0[i]), i);

    phase = 4;
    wait_pos(50);
    snap = frames_done;
    video_en = 1'b0;
    wait_idle();
    repeat (10) @(posedge pclk);
    #1 check("mid_frame_drop_completes", frames_done - snap, 1);
    snap = de_total;
    repeat (40) @(posedge pclk);
    #1 check("idle_after_drop", de_total - snap, 0);
    salt = 8'($urandom);
    video_en = 1'b1;
    wait_frames(1);

    phase = 5;
    wait_pos(3 * int'(HT) + 7);
    rstin = 1'b1;
    video_en = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check("reset_de", 32'(vid.video_de), 32'(0));
    check("reset_data_req", 32'(vid.data_req), 32'(0));
    check("reset_din", 32'(vid.video_din), 32'(0));
    @(posedge pclk); #1 rstin = 1'b0;
    snap = req_total;
    repeat (30) @(posedge pclk);
    #1 check("no_restart_without_en", req_total - snap, 0);

    phase = 6;
    salt = 8'($urandom);
    video_en = 1'b1;
    for (int i = 0; i < 900; i++) begin
      @(posedge pclk); #1;
      if (rstin) rstin = 1'b0;
      else if ($urandom_range(0, 299) == 0) begin
        rstin = 1'b1;
        salt = 8'($urandom);
`ifdef TEST_PATTERN_EN
        test_sel = 1'($urandom);
`endif
      end
      if ($urandom_range(0, 99) < 2) video_en = ~video_en;
    end
    rstin = 1'b0;
    video_en = 1'b0;
    wait_idle();
    repeat (5) @(posedge pclk);

`ifdef TEST_PATTERN_EN
    #1;
    phase = 7;
    test_sel = 1'b1;
    video_en = 1'b1;
    wait_frames(1);
    video_en = 1'b0;
    for (int i = 0; i < 8; i++) check("bar_colour", 32'(bars[i]), 32'(bar_rgb(i)));
    wait_idle();
    repeat (5) @(posedge pclk);
`endif

    #1;
    check("req_queue_drained", req_q.size(), 0);
    check("pix_queue_drained", pix_q.size(), 0);
    check("ctl_queue_drained", ctl_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
